// File: rtl/cluster_clint.sv
// cluster_clint: core-local interruptor behind a 32-bit valid/ready register port.
// Holds per-hart msip bits and, when CLINT_TIMER_EN is defined, a prescaled
// 64-bit mtime plus per-hart 64-bit mtimecmp registers driving mtip_o.
// Without CLINT_TIMER_EN only msip exists; timer offsets decode as errors.
module cluster_clint #(
  parameter int unsigned NumCores  = 8,
  parameter int unsigned Prescaler = 1,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 time_en_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_strb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NumCores-1:0]  msip_o,
  output logic [NumCores-1:0]  mtip_o
);

  logic [15:0]         offset;
  logic                upper_zero;
  logic                req_fire;
  logic                wr_fire;
  logic                sel_msip;
  logic                sel_cmp;
  logic                sel_time;
  logic                dec_err;
  logic [12:0]         idx;
  logic [31:0]         rd_data;
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_error_q;
  logic [NumCores-1:0] msip_q;

  assign offset     = req_addr_i[15:0];
  assign upper_zero = (req_addr_i >> 16) == '0;

  // Only one request in flight: a new one may enter when the response slot
  // is empty or is being drained this very cycle.
  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_fire    = req_valid_i && req_ready_o;
  assign wr_fire     = req_fire && req_write_i && !dec_err;

`ifdef CLINT_TIMER_EN
  logic [63:0]         mtime_q;
  logic [31:0]         presc_q;
  logic [63:0]         mtimecmp_q [NumCores];
  logic [NumCores-1:0] mtip_q;
  logic                tick;
  logic                word_hi;

  assign word_hi = offset[2];
  assign tick    = time_en_i && (presc_q == 32'(Prescaler - 1));

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction
`endif

  // Address decode: pick the register bank and hart index, flag anything unmapped.
  always_comb begin
    sel_msip = 1'b0;
    sel_cmp  = 1'b0;
    sel_time = 1'b0;
    idx      = '0;
    if (offset < 16'h4000) begin
      idx      = {1'b0, offset[13:2]};
      sel_msip = 32'(idx) < NumCores;
    end
`ifdef CLINT_TIMER_EN
    else if (offset[15:3] == 13'h17FF) begin
      sel_time = 1'b1;
    end else if (offset < 16'hC000) begin
      idx     = offset[15:3] - 13'h0800;
      sel_cmp = 32'(idx) < NumCores;
    end
`endif
    dec_err = !upper_zero || (offset[1:0] != 2'b00) || !(sel_msip || sel_cmp || sel_time);
  end

  // Read mux on current register state; writes and errors return zero.
  always_comb begin
    rd_data = '0;
    if (sel_msip) begin
      for (int i = 0; i < NumCores; i++) begin
        if (idx == 13'(i)) rd_data = {31'b0, msip_q[i]};
      end
    end
`ifdef CLINT_TIMER_EN
    if (sel_cmp) begin
      for (int i = 0; i < NumCores; i++) begin
        if (idx == 13'(i)) rd_data = word_hi ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
      end
    end
    if (sel_time) rd_data = word_hi ? mtime_q[63:32] : mtime_q[31:0];
`endif
    if (dec_err || req_write_i) rd_data = '0;
  end

  // Registered response slot, held stable until the consumer takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= rd_data;
      rsp_error_q <= dec_err;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Software interrupt bits; only byte 0 bit 0 is stored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip_q <= '0;
    end else if (wr_fire && sel_msip && req_strb_i[0]) begin
      for (int i = 0; i < NumCores; i++) begin
        if (idx == 13'(i)) msip_q[i] <= req_wdata_i[0];
      end
    end
  end

`ifdef CLINT_TIMER_EN
  // Prescaler runs only while the timebase is enabled; software writes never reset it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (time_en_i) begin
      presc_q <= tick ? '0 : presc_q + 32'd1;
    end
  end

  // mtime: a software write to either word wins over the increment that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q <= '0;
    end else if (wr_fire && sel_time) begin
      if (word_hi) mtime_q[63:32] <= merge_bytes(mtime_q[63:32], req_wdata_i, req_strb_i);
      else         mtime_q[31:0]  <= merge_bytes(mtime_q[31:0], req_wdata_i, req_strb_i);
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // Per-hart compare registers, reset to all ones so no timer fires early.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCores; i++) mtimecmp_q[i] <= '1;
    end else if (wr_fire && sel_cmp) begin
      for (int i = 0; i < NumCores; i++) begin
        if (idx == 13'(i)) begin
          if (word_hi) mtimecmp_q[i][63:32] <= merge_bytes(mtimecmp_q[i][63:32], req_wdata_i, req_strb_i);
          else         mtimecmp_q[i][31:0]  <= merge_bytes(mtimecmp_q[i][31:0], req_wdata_i, req_strb_i);
        end
      end
    end
  end

  // Timer pending is registered, so it trails register updates by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtip_q <= '0;
    end else begin
      for (int i = 0; i < NumCores; i++) mtip_q[i] <= mtime_q >= mtimecmp_q[i];
    end
  end

  assign mtip_o = mtip_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{time_en_i, req_wdata_i[31:1], req_strb_i[3:1], 32'(Prescaler)};
  assign mtip_o = '0;
`endif

  assign msip_o      = msip_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_cluster_clint.sv
// tb_cluster_clint: self-checking bench for cluster_clint. Expected responses
// are queued when a request is issued and popped when the response appears.
module tb_cluster_clint;

  localparam int NC    = 8;
  localparam int AW    = 20;
  localparam int PRESC = 4;

  logic          clk;
  logic          rst;
  logic          time_en;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [31:0]   req_wdata;
  logic [3:0]    req_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [NC-1:0] msip;
  logic [NC-1:0] mtip;

  int          checks   = 0;
  int          failures = 0;
  logic [32:0] exp_q [$];

  cluster_clint #(.NumCores(NC), .Prescaler(PRESC), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst), .time_en_i(time_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .msip_o(msip), .mtip_o(mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full request/response exchange with rsp_ready held high.
  // Returns at the negedge right after the accept edge, response sampled there.
  task automatic transact(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_strb = s; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("[TB] FAIL timeout addr=%h: got rsp_valid=%0b, expected 1", a, rsp_valid);
    end
    rd = rsp_rdata;
    er = rsp_error;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (msip !== '0) begin failures++; $display("[TB] FAIL rst_msip: got %h expected 00", msip); end
    checks++; if (mtip !== '0) begin failures++; $display("[TB] FAIL rst_mtip: got %h expected 00", mtip); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_data: got rdata=%h err=%0b expected 0/0", rsp_rdata, rsp_error); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_req_ready: got %0b expected 1", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_msip();
    logic [31:0] rd; logic er; logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h0});
    transact(20'h00008, 1'b1, 32'h1, 4'hF, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL msip_wr: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    checks++; if (msip !== 8'h04) begin failures++; $display("[TB] FAIL msip_hart2: got %h expected 04", msip); end
    exp_q.push_back({1'b0, 32'h1});
    transact(20'h00008, 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL msip_rd: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    exp_q.push_back({1'b0, 32'h0});
    transact(20'h00008, 1'b1, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL msip_strb0: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    checks++; if (msip !== 8'h04) begin failures++; $display("[TB] FAIL msip_strb0_hold: got %h expected 04", msip); end
    exp_q.push_back({1'b0, 32'h0});
    transact(20'h0001C, 1'b1, 32'hFFFF_FFFF, 4'h1, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL msip_wr7: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    checks++; if (msip !== 8'h84) begin failures++; $display("[TB] FAIL msip_hart7: got %h expected 84", msip); end
    exp_q.push_back({1'b0, 32'h1});
    transact(20'h0001C, 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL msip_rd7: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    transact(20'h0001C, 1'b1, 32'h0, 4'hF, rd, er);
    checks++; if (msip !== 8'h04) begin failures++; $display("[TB] FAIL msip_clr7: got %h expected 04", msip); end
  endtask

  task automatic test_decode_errors();
    logic [31:0] rd; logic er; logic [32:0] exp;
    logic [AW-1:0] bad [5];
    bad = '{20'h00002, 20'h00020, 20'h08000, 20'h10008, 20'h03FFC};
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({1'b1, 32'h0});
      transact(bad[k], 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
      checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL err_rd_%h: got err=%0b rdata=%h expected err=%0b rdata=%h", bad[k], er, rd, exp[32], exp[31:0]); end
    end
    exp_q.push_back({1'b1, 32'h0});
    transact(20'h00020, 1'b1, 32'h1, 4'hF, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL err_wr_hart8: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    exp_q.push_back({1'b1, 32'h0});
    transact(20'h00009, 1'b1, 32'h0, 4'hF, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL err_wr_unaligned: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    checks++; if (msip !== 8'h04) begin failures++; $display("[TB] FAIL err_wr_no_effect: got %h expected 04", msip); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 20'h00008; req_write = 1'b0; req_strb = 4'h0; rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h1});
    @(negedge clk);
    req_addr = 20'h0000C; req_write = 1'b1; req_wdata = 32'h1; req_strb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1 || rsp_error !== 1'b0) begin failures++; $display("[TB] FAIL stall_rsp_%0d: got valid=%0b rdata=%h err=%0b expected 1/00000001/0", k, rsp_valid, rsp_rdata, rsp_error); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready_%0d: got %0b expected 0", k, req_ready); end
      checks++; if (msip !== 8'h04) begin failures++; $display("[TB] FAIL stall_no_write_%0d: got %h expected 04", k, msip); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    exp = exp_q.pop_front();
    checks++; if ({rsp_error, rsp_rdata} !== exp) begin failures++; $display("[TB] FAIL b2b_first: got err=%0b rdata=%h expected err=%0b rdata=%h", rsp_error, rsp_rdata, exp[32], exp[31:0]); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %0b expected 1", req_ready); end
    exp_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (rsp_valid !== 1'b1 || {rsp_error, rsp_rdata} !== exp) begin failures++; $display("[TB] FAIL b2b_second: got valid=%0b err=%0b rdata=%h expected valid=1 err=%0b rdata=%h", rsp_valid, rsp_error, rsp_rdata, exp[32], exp[31:0]); end
    checks++; if (msip !== 8'h0C) begin failures++; $display("[TB] FAIL b2b_msip: got %h expected 0c", msip); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_retire: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 20'h00014; req_write = 1'b1; req_wdata = 32'h1; req_strb = 4'hF; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; rst = 1'b0;
    checks++; if (msip !== 8'h00) begin failures++; $display("[TB] FAIL abort_write: got %h expected 00", msip); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_rsp: got %0b expected 0", rsp_valid); end
    req_valid = 1'b1; req_addr = 20'h00000; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL abort_pending: got %0b expected 1", rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL abort_drop: got valid=%0b rdata=%h expected 0/00000000", rsp_valid, rsp_rdata); end
  endtask

`ifdef CLINT_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd; logic er; logic [32:0] exp;
    logic [AW-1:0] addr_l [7];
    logic [32:0]   exp_l  [7];
    @(negedge clk); rst = 1'b1; time_en = 1'b0;
    @(negedge clk); rst = 1'b0; time_en = 1'b1;
    repeat (40) @(negedge clk);
    time_en = 1'b0;
    addr_l = '{20'h0BFF8, 20'h0BFFC, 20'h04000, 20'h0403C, 20'h04040, 20'h0BFF8, 20'h0BFFC};
    exp_l  = '{{1'b0, 32'd10}, {1'b0, 32'd0}, {1'b0, 32'hFFFF_FFFF}, {1'b0, 32'hFFFF_FFFF},
               {1'b1, 32'h0}, {1'b0, 32'd10}, {1'b0, 32'd0}};
    for (int k = 0; k < 7; k++) begin
      if (k == 5) repeat (20) @(negedge clk);
      exp_q.push_back(exp_l[k]);
      transact(addr_l[k], 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
      checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL timer_rd_%0d_%h: got err=%0b rdata=%h expected err=%0b rdata=%h", k, addr_l[k], er, rd, exp[32], exp[31:0]); end
    end
    checks++; if (mtip !== 8'h00) begin failures++; $display("[TB] FAIL mtip_idle: got %h expected 00", mtip); end
    transact(20'h04004, 1'b1, 32'h0, 4'hF, rd, er);
    transact(20'h04000, 1'b1, 32'h5, 4'hF, rd, er);
    repeat (2) @(negedge clk);
    checks++; if (mtip !== 8'h01) begin failures++; $display("[TB] FAIL mtip_set: got %h expected 01", mtip); end
    transact(20'h0BFF8, 1'b1, 32'h4, 4'hF, rd, er);
    checks++; if (mtip !== 8'h01) begin failures++; $display("[TB] FAIL mtip_lag_clr: got %h expected 01", mtip); end
    @(negedge clk);
    checks++; if (mtip !== 8'h00) begin failures++; $display("[TB] FAIL mtip_below: got %h expected 00", mtip); end
    transact(20'h0BFF8, 1'b1, 32'h5, 4'hF, rd, er);
    checks++; if (mtip !== 8'h00) begin failures++; $display("[TB] FAIL mtip_lag_set: got %h expected 00", mtip); end
    @(negedge clk);
    checks++; if (mtip !== 8'h01) begin failures++; $display("[TB] FAIL mtip_equal: got %h expected 01", mtip); end
    transact(20'h04004, 1'b1, 32'h1, 4'hF, rd, er);
    checks++; if (mtip !== 8'h01) begin failures++; $display("[TB] FAIL mtip_lag_hi: got %h expected 01", mtip); end
    @(negedge clk);
    checks++; if (mtip !== 8'h00) begin failures++; $display("[TB] FAIL mtip_cmp_hi: got %h expected 00", mtip); end
    transact(20'h0BFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er);
    transact(20'h0BFF8, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, er);
    @(negedge clk); time_en = 1'b1;
    repeat (3 * PRESC) @(negedge clk);
    time_en = 1'b0;
    exp_q.push_back({1'b0, 32'h1});
    transact(20'h0BFF8, 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL wrap_lo: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    exp_q.push_back({1'b0, 32'h0});
    transact(20'h0BFFC, 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL wrap_hi: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    @(negedge clk); time_en = 1'b1;
    repeat (PRESC - 1) @(negedge clk);
    req_valid = 1'b1; req_addr = 20'h0BFF8; req_write = 1'b1; req_wdata = 32'h0000_00AB; req_strb = 4'h1; rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    @(negedge clk);
    time_en = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (rsp_valid !== 1'b1 || {rsp_error, rsp_rdata} !== exp) begin failures++; $display("[TB] FAIL prio_rsp: got valid=%0b err=%0b rdata=%h expected valid=1 err=%0b rdata=%h", rsp_valid, rsp_error, rsp_rdata, exp[32], exp[31:0]); end
    exp_q.push_back({1'b0, 32'h0000_00AB});
    transact(20'h0BFF8, 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL prio_value: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] rd; logic er; logic [32:0] exp;
    logic [AW-1:0] addr_l [3];
    addr_l = '{20'h0BFF8, 20'h0BFFC, 20'h04000};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b1, 32'h0});
      transact(addr_l[k], 1'b0, 32'h0, 4'h0, rd, er); exp = exp_q.pop_front();
      checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL notimer_rd_%h: got err=%0b rdata=%h expected err=%0b rdata=%h", addr_l[k], er, rd, exp[32], exp[31:0]); end
    end
    exp_q.push_back({1'b1, 32'h0});
    transact(20'h0BFF8, 1'b1, 32'h0, 4'hF, rd, er); exp = exp_q.pop_front();
    checks++; if ({er, rd} !== exp) begin failures++; $display("[TB] FAIL notimer_wr: got err=%0b rdata=%h expected err=%0b rdata=%h", er, rd, exp[32], exp[31:0]); end
    time_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (mtip !== 8'h00) begin failures++; $display("[TB] FAIL notimer_mtip: got %h expected 00", mtip); end
    time_en = 1'b0;
  endtask
`endif

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; time_en = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_wdata = '0; req_strb = '0; rsp_ready = 1'b1;
    test_reset();
    test_msip();
    test_decode_errors();
    test_back_to_back();
    test_reset_abort();
`ifdef CLINT_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
